leq: RTL and testbench

LEQ -- requirements
Module: leq

---
 rtl/leq.sv | 153 +++++++++++++++
 tb/tb_leq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/leq.sv
// One non-root level of a pipelined heap: reads its own node plus both children,
// then writes the node back and hands an item/position to the next level down.
package pq_pkg;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] value;
  } kv_t;

  localparam kv_t KV_EMPTY = '{key: 8'hFF, value: 8'h00};
endpackage

package pheapTypes;
  localparam int LEVELS = 3;
  localparam int CW = $clog2(2 ** LEVELS);

  typedef struct packed {
    logic            valid;
    logic [CW-1:0]   cap;
    pq_pkg::kv_t     kv;
  } entry_t;

  typedef enum logic [1:0] {FREE, LEQ, DEQ, ENQ_DEQ} opcode_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, NEXT_LEVEL} done_t;
endpackage

module leq #(
  parameter int LEVEL  = 2,
  parameter int LEVELS = pheapTypes::LEVELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEVEL-2:0]      startPos,
  input  pq_pkg::kv_t           in,
  input  pheapTypes::opcode_t   op,
  input  pheapTypes::entry_t    rTop,
  input  pheapTypes::entry_t    rBotL,
  input  pheapTypes::entry_t    rBotR,
  output logic [LEVEL-2:0]      raddrTop,
  output logic [LEVEL-2:0]      wraddrTop,
  output logic [LEVEL-1:0]      raddrBot,
  output logic                  wenTop,
  output pheapTypes::entry_t    wData,
  output logic                  active,
  output pheapTypes::done_t     done,
  output pq_pkg::kv_t           out,
  output logic [LEVEL-1:0]      endPos
);
  localparam int CW = $clog2(2 ** LEVELS);

  typedef enum logic {S_IDLE, S_EVAL} state_t;

  state_t              state_reg, state_next;
  pheapTypes::opcode_t op_reg;
  pq_pkg::kv_t         in_reg;
  logic [LEVEL-2:0]    pos_reg;

  logic                keep_in;
  logic                any_child;
  logic                pick_r;
  pq_pkg::kv_t         child_kv;
  logic [CW-1:0]       cap_dn, cap_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      op_reg    <= pheapTypes::FREE;
      in_reg    <= pq_pkg::KV_EMPTY;
      pos_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start) begin
        op_reg  <= op;
        in_reg  <= in;
        pos_reg <= startPos;
      end
    end
  end

  // Tie on insert keeps the resident item; tie between children picks left.
  assign keep_in   = in_reg.key < rTop.kv.key;
  assign any_child = rBotL.valid || rBotR.valid;
  assign pick_r    = rBotR.valid && (!rBotL.valid || (rBotR.kv.key < rBotL.kv.key));
  assign child_kv  = pick_r ? rBotR.kv : rBotL.kv;
  assign cap_dn    = rTop.cap - CW'(1);
  assign cap_up    = rTop.cap + CW'(1);

  always_comb begin
    state_next = state_reg;
    raddrTop   = startPos;
    raddrBot   = {startPos, 1'b0};
    wraddrTop  = pos_reg;
    wenTop     = 1'b0;
    wData      = rTop;
    active     = 1'b0;
    done       = pheapTypes::IDLE;
    out        = pq_pkg::KV_EMPTY;
    endPos     = '0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_EVAL;
          active     = 1'b1;
          done       = pheapTypes::BUSY;
        end
      end
      S_EVAL: begin
        state_next = S_IDLE;
        raddrTop   = pos_reg;
        raddrBot   = {pos_reg, 1'b0};
        active     = 1'b1;
        wenTop     = !rst;
        done       = pheapTypes::DONE;
        unique case (op_reg)
          pheapTypes::FREE: wenTop = 1'b0;
          pheapTypes::LEQ: begin
            if (!rTop.valid) begin
              wData = {1'b1, cap_dn, in_reg};
            end else begin
              wData = {1'b1, cap_dn, keep_in ? in_reg : rTop.kv};
              // Larger item descends into whichever subtree still has room.
              if (rBotL.cap != '0 || rBotR.cap != '0) begin
                out    = keep_in ? rTop.kv : in_reg;
                endPos = {pos_reg, (rBotL.cap == '0)};
                done   = pheapTypes::NEXT_LEVEL;
              end
            end
          end
          pheapTypes::DEQ: begin
            if (any_child) begin
              wData  = {1'b1, cap_up, child_kv};
              endPos = {pos_reg, pick_r};
              done   = pheapTypes::NEXT_LEVEL;
            end else begin
              wData = {1'b0, cap_up, pq_pkg::KV_EMPTY};
            end
          end
          pheapTypes::ENQ_DEQ: begin
            if (!any_child || in_reg.key <= child_kv.key) begin
              wData = {1'b1, rTop.cap, in_reg};
            end else begin
              wData  = {1'b1, rTop.cap, child_kv};
              out    = in_reg;
              endPos = {pos_reg, pick_r};
              done   = pheapTypes::NEXT_LEVEL;
            end
          end
        endcase
      end
    endcase
  end
endmodule

// File: tb/tb_leq.sv
// Directed scoreboard bench for one heap level (LEVEL=2, LEVELS=3).
module tb_leq;
  import pq_pkg::kv_t;
  import pheapTypes::entry_t;
  import pheapTypes::opcode_t;
  import pheapTypes::done_t;

  localparam int LEVEL = 2;

  typedef struct {
    logic              wen;
    logic [LEVEL-2:0]  wraddr;
    entry_t            wdata;
    kv_t               out;
    logic [LEVEL-1:0]  endpos;
    done_t             done;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEVEL-2:0] startPos;
  kv_t              in;
  opcode_t          op;
  entry_t           rTop, rBotL, rBotR;
  logic [LEVEL-2:0] raddrTop, wraddrTop;
  logic [LEVEL-1:0] raddrBot;
  logic             wenTop;
  entry_t           wData;
  logic             active;
  done_t            done;
  kv_t              out;
  logic [LEVEL-1:0] endPos;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  leq #(.LEVEL(LEVEL), .LEVELS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .startPos(startPos), .in(in), .op(op),
    .rTop(rTop), .rBotL(rBotL), .rBotR(rBotR),
    .raddrTop(raddrTop), .wraddrTop(wraddrTop), .raddrBot(raddrBot),
    .wenTop(wenTop), .wData(wData), .active(active), .done(done),
    .out(out), .endPos(endPos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic kv_t kv(input logic [7:0] k, input logic [7:0] v);
    kv_t r;
    r.key   = k;
    r.value = v;
    return r;
  endfunction

  function automatic entry_t ent(input logic v, input logic [2:0] c, input kv_t x);
    entry_t r;
    r.valid = v;
    r.cap   = c;
    r.kv    = x;
    return r;
  endfunction

  function automatic exp_t ex(input logic w, input logic [LEVEL-2:0] a, input entry_t d,
                              input kv_t o, input logic [LEVEL-1:0] e, input done_t dn);
    exp_t r;
    r.wen = w; r.wraddr = a; r.wdata = d; r.out = o; r.endpos = e; r.done = dn;
    return r;
  endfunction

  // Waits (bounded) for the result cycle and compares it against the queue head.
  task automatic wait_result();
    int   n = 0;
    exp_t e;
    #1;
    while (!(done == pheapTypes::DONE || done == pheapTypes::NEXT_LEVEL) && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    if (!(done == pheapTypes::DONE || done == pheapTypes::NEXT_LEVEL)) begin
      check("result_timeout", done, e.done);
      return;
    end
    $display("op result: wen=%0b waddr=%0h wdata=%0h out=%0h endpos=%0h done=%0d",
             wenTop, wraddrTop, wData, out, endPos, done);
    check("wen", wenTop, e.wen);
    check("wraddr", wraddrTop, e.wraddr);
    check("raddr_hold", raddrTop, e.wraddr);
    check("raddrbot_hold", raddrBot, {e.wraddr, 1'b0});
    if (e.wen) check("wdata", wData, e.wdata);
    check("out", out, e.out);
    check("endpos", endPos, e.endpos);
    check("done", done, e.done);
    check("active_eval", active, 1'b1);
  endtask

  task automatic run_op(input opcode_t o, input kv_t i, input logic [LEVEL-2:0] p,
                        input entry_t top, input entry_t bl, input entry_t br, input exp_t e);
    @(negedge clk);
    start = 1'b1; op = o; in = i; startPos = p;
    #1;
    check("busy", done, pheapTypes::BUSY);
    check("active_start", active, 1'b1);
    check("raddr_top", raddrTop, p);
    check("raddr_bot", raddrBot, {p, 1'b0});
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; op = pheapTypes::FREE; in = pq_pkg::KV_EMPTY; startPos = ~p;
    rTop = top; rBotL = bl; rBotR = br;
    wait_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t e0;
    kv_t    ke;
    e0 = '0;
    ke = pq_pkg::KV_EMPTY;
    rst = 1'b1; start = 1'b0; startPos = '0; in = ke; op = pheapTypes::FREE;
    rTop = e0; rBotL = e0; rBotR = e0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_done", done, pheapTypes::IDLE);
    check("reset_wen", wenTop, 1'b0);
    check("reset_active", active, 1'b0);
    check("reset_out", out, ke);
    check("reset_endpos", endPos, 2'd0);

    // Insert into empty node, then descending inserts.
    run_op(pheapTypes::LEQ, kv(5, 8'h55), 1, ent(0, 3, ke), e0, e0,
           ex(1, 1, ent(1, 2, kv(5, 8'h55)), ke, 0, pheapTypes::DONE));
    run_op(pheapTypes::LEQ, kv(7, 8'h77), 1, ent(1, 3, kv(3, 8'h33)),
           ent(1, 1, kv(10, 8'hA0)), ent(1, 1, kv(12, 8'hC0)),
           ex(1, 1, ent(1, 2, kv(3, 8'h33)), kv(7, 8'h77), 2, pheapTypes::NEXT_LEVEL));
    run_op(pheapTypes::LEQ, kv(2, 8'h22), 0, ent(1, 3, kv(3, 8'h33)),
           e0, ent(1, 2, kv(9, 8'h99)),
           ex(1, 0, ent(1, 2, kv(2, 8'h22)), kv(3, 8'h33), 1, pheapTypes::NEXT_LEVEL));
    run_op(pheapTypes::LEQ, kv(3, 8'hEE), 1, ent(1, 4, kv(3, 8'h33)),
           ent(1, 2, kv(8, 8'h80)), e0,
           ex(1, 1, ent(1, 3, kv(3, 8'h33)), kv(3, 8'hEE), 2, pheapTypes::NEXT_LEVEL));
    run_op(pheapTypes::LEQ, kv(9, 8'h99), 1, ent(1, 1, kv(3, 8'h33)), e0, e0,
           ex(1, 1, ent(1, 0, kv(3, 8'h33)), ke, 0, pheapTypes::DONE));

    // Dequeue: smaller child, empty children, tie, invalid-but-smaller left.
    run_op(pheapTypes::DEQ, ke, 1, ent(1, 1, kv(3, 8'h33)),
           ent(1, 1, kv(9, 8'h99)), ent(1, 1, kv(6, 8'h66)),
           ex(1, 1, ent(1, 2, kv(6, 8'h66)), ke, 3, pheapTypes::NEXT_LEVEL));
    run_op(pheapTypes::DEQ, ke, 1, ent(1, 1, kv(3, 8'h33)), e0, e0,
           ex(1, 1, ent(0, 2, ke), ke, 0, pheapTypes::DONE));
    run_op(pheapTypes::DEQ, ke, 0, ent(1, 1, kv(3, 8'h33)),
           ent(1, 1, kv(6, 8'h61)), ent(1, 1, kv(6, 8'h62)),
           ex(1, 0, ent(1, 2, kv(6, 8'h61)), ke, 0, pheapTypes::NEXT_LEVEL));
    run_op(pheapTypes::DEQ, ke, 1, ent(1, 1, kv(3, 8'h33)),
           ent(0, 0, kv(1, 8'h11)), ent(1, 1, kv(8, 8'h88)),
           ex(1, 1, ent(1, 2, kv(8, 8'h88)), ke, 3, pheapTypes::NEXT_LEVEL));

    // Replace: new item stays, smaller child rises, tie keeps new item.
    run_op(pheapTypes::ENQ_DEQ, kv(4, 8'h44), 1, ent(1, 2, kv(2, 8'h22)),
           ent(1, 1, kv(6, 8'h66)), ent(1, 1, kv(9, 8'h99)),
           ex(1, 1, ent(1, 2, kv(4, 8'h44)), ke, 0, pheapTypes::DONE));
    run_op(pheapTypes::ENQ_DEQ, kv(8, 8'h88), 1, ent(1, 2, kv(2, 8'h22)),
           ent(1, 1, kv(9, 8'h99)), ent(1, 1, kv(6, 8'h66)),
           ex(1, 1, ent(1, 2, kv(6, 8'h66)), kv(8, 8'h88), 3, pheapTypes::NEXT_LEVEL));
    run_op(pheapTypes::ENQ_DEQ, kv(6, 8'hF0), 0, ent(1, 2, kv(2, 8'h22)),
           ent(1, 1, kv(6, 8'h61)), ent(1, 1, kv(9, 8'h99)),
           ex(1, 0, ent(1, 2, kv(6, 8'hF0)), ke, 0, pheapTypes::DONE));
    run_op(pheapTypes::ENQ_DEQ, kv(20, 8'h20), 1, ent(1, 5, kv(2, 8'h22)), e0, e0,
           ex(1, 1, ent(1, 5, kv(20, 8'h20)), ke, 0, pheapTypes::DONE));
    run_op(pheapTypes::FREE, kv(1, 8'h01), 1, ent(1, 2, kv(2, 8'h22)), e0, e0,
           ex(0, 1, e0, ke, 0, pheapTypes::DONE));

    // Start held high through the evaluation cycle must be ignored.
    @(negedge clk);
    start = 1'b1; op = pheapTypes::LEQ; in = kv(5, 8'h55); startPos = 1;
    exp_q.push_back(ex(1, 1, ent(1, 2, kv(5, 8'h55)), ke, 0, pheapTypes::DONE));
    @(negedge clk);
    op = pheapTypes::DEQ; in = kv(1, 8'h01); startPos = 0;
    rTop = ent(0, 3, ke); rBotL = e0; rBotR = e0;
    wait_result();
    @(negedge clk);
    start = 1'b0;
    #1;
    check("ignored_start_done", done, pheapTypes::IDLE);
    check("ignored_start_active", active, 1'b0);
    check("ignored_start_wen", wenTop, 1'b0);
    run_op(pheapTypes::LEQ, kv(4, 8'h44), 0, ent(0, 2, ke), e0, e0,
           ex(1, 0, ent(1, 1, kv(4, 8'h44)), ke, 0, pheapTypes::DONE));

    // Reset during evaluation aborts without a write.
    @(negedge clk);
    start = 1'b1; op = pheapTypes::LEQ; in = kv(5, 8'h55); startPos = 1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1; rTop = ent(0, 3, ke);
    #1;
    check("rst_mid_wen", wenTop, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_done", done, pheapTypes::IDLE);
    check("rst_mid_active", active, 1'b0);
    check("rst_mid_out", out, ke);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
